// File: rtl/drone_pwm_pkg.sv
// Shared constants and state encoding for the ESC PWM drive path.
package drone_pwm_pkg;

    localparam logic [7:0] DUTY_MAX         = 8'h64;
    localparam logic [7:0] DUTY_IDLE        = 8'h32;
    localparam int         STEPS_PER_PERIOD = 100;

    typedef enum logic [1:0] {
        ARMING = 2'd0,
        RUN    = 2'd1,
        SAFE   = 2'd2
    } esc_state_t;

endpackage

// File: rtl/pwm_period_timer.sv
// PWM period timebase: prescaler of CLK_DIV clocks feeding a 0..99 duty step counter.
module pwm_period_timer
    import drone_pwm_pkg::*;
#(
    parameter int CLK_DIV = 500
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic [6:0] step,
    output logic       period_start_int,
    output logic       period_end
);

    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [PW-1:0] presc_q, presc_d;
    logic [6:0]    step_q, step_d;
    logic          presc_last, step_last;

    assign presc_last = (presc_q == PW'(CLK_DIV - 1));
    assign step_last  = (step_q == 7'(STEPS_PER_PERIOD - 1));

    always_comb begin
        presc_d = presc_last ? '0 : presc_q + PW'(1);
        step_d  = step_q;
        if (presc_last) begin
            step_d = step_last ? 7'd0 : step_q + 7'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            presc_q <= '0;
            step_q  <= '0;
        end else begin
            presc_q <= presc_d;
            step_q  <= step_d;
        end
    end

    assign step             = step_q;
    assign period_start_int = (presc_q == '0) && (step_q == 7'd0);
    assign period_end       = presc_last && step_last;

endmodule

// File: rtl/esc_pwm_driver.sv
// Single-ESC PWM driver with arming sequence, kill path and period-synchronous duty latch.
// Optional per-period slew limiting of the active duty is compiled in with SLEW_LIMIT_EN.
module esc_pwm_driver
    import drone_pwm_pkg::*;
#(
    parameter int CLK_DIV     = 500,
    parameter int ARM_PERIODS = 200,
    parameter int MAX_STEP    = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] duty_in,
    input  logic       kill,
    output logic       pwm_out,
    output logic       armed,
    output logic       period_start,
    output logic       duty_clamped
);

    localparam int AW = (ARM_PERIODS > 1) ? $clog2(ARM_PERIODS + 1) : 1;

    function automatic logic [7:0] sat_duty(input logic [7:0] d);
        return (d > DUTY_MAX) ? DUTY_MAX : d;
    endfunction

    function automatic logic [7:0] slew_toward(input logic [7:0] cur, input logic [7:0] tgt);
        logic [7:0] lim;
        lim = 8'(MAX_STEP);
        if (tgt > cur + lim) begin
            return cur + lim;
        end else if (cur > tgt + lim) begin
            return cur - lim;
        end
        return tgt;
    endfunction

    logic [6:0]    step;
    logic          period_start_int, period_end;
    esc_state_t    state_q, state_d;
    logic [AW-1:0] arm_cnt_q, arm_cnt_d;
    logic [7:0]    duty_q, duty_d;
    logic          clamp_q, clamp_d;
    logic          pwm_q, armed_q, pstart_q, dclamp_q;
    logic [7:0]    target;
    logic          over;

    pwm_period_timer #(
        .CLK_DIV(CLK_DIV)
    ) u_timer (
        .clk              (clk),
        .rst_n            (rst_n),
        .step             (step),
        .period_start_int (period_start_int),
        .period_end       (period_end)
    );

    assign target = sat_duty(duty_in);
    assign over   = (duty_in > DUTY_MAX);

    always_comb begin
        state_d   = state_q;
        arm_cnt_d = arm_cnt_q;
        duty_d    = duty_q;
        clamp_d   = clamp_q;

        // kill overrides everything, including the boundary that would finish arming
        if (kill) begin
            state_d = SAFE;
        end else if (period_end) begin
            unique case (state_q)
                ARMING: begin
                    if (arm_cnt_q == AW'(ARM_PERIODS - 1)) begin
                        state_d = RUN;
                    end else begin
                        arm_cnt_d = arm_cnt_q + AW'(1);
                    end
                end
                SAFE: begin
                    state_d   = ARMING;
                    arm_cnt_d = '0;
                end
                default: ;
            endcase
        end

        if (period_end) begin
            if (state_d == RUN) begin
`ifdef SLEW_LIMIT_EN
                duty_d = slew_toward(duty_q, target);
`else
                duty_d = target;
`endif
                clamp_d = over;
            end else begin
                duty_d  = DUTY_IDLE;
                clamp_d = 1'b0;
            end
        end
    end

    // Outputs lag the counters by one clock so armed/duty_clamped line up with period_start.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ARMING;
            arm_cnt_q <= '0;
            duty_q    <= DUTY_IDLE;
            clamp_q   <= 1'b0;
            pwm_q     <= 1'b0;
            armed_q   <= 1'b0;
            pstart_q  <= 1'b0;
            dclamp_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            arm_cnt_q <= arm_cnt_d;
            duty_q    <= duty_d;
            clamp_q   <= clamp_d;
            pwm_q     <= ({1'b0, step} < duty_q);
            armed_q   <= (state_q == RUN);
            pstart_q  <= period_start_int;
            dclamp_q  <= clamp_q;
        end
    end

    assign pwm_out      = pwm_q;
    assign armed        = armed_q;
    assign period_start = pstart_q;
    assign duty_clamped = dclamp_q;

endmodule

// File: tb/tb_esc_pwm_driver.sv
// Scoreboard bench for esc_pwm_driver with CLK_DIV=4, ARM_PERIODS=3, MAX_STEP=2.
module tb_esc_pwm_driver;

    localparam int CLK_DIV = 4;
    localparam int ARM_P   = 3;
    localparam int MAXS    = 2;
    localparam int PERIOD  = CLK_DIV * 100;

    typedef struct {
        int hi;
        int clamp;
        int armed;
    } exp_t;

    typedef struct {
        int idx;
        int len;
        int hi;
        int clamp;
        int armed;
        int rises;
    } obs_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] duty_in;
    logic       kill;
    logic       pwm_out, armed, period_start, duty_clamped;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];
    obs_t obs_q[$];
    obs_t cur;
    bit   in_per = 0;
    bit   prev_pwm = 0;
    int   pcount = 0;
    logic [7:0] m_duty;
    bit   m_clamp;

    always #5 clk = ~clk;

    esc_pwm_driver #(
        .CLK_DIV     (CLK_DIV),
        .ARM_PERIODS (ARM_P),
        .MAX_STEP    (MAXS)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .duty_in      (duty_in),
        .kill         (kill),
        .pwm_out      (pwm_out),
        .armed        (armed),
        .period_start (period_start),
        .duty_clamped (duty_clamped)
    );

    // Per-period monitor: one record per completed period, delimited by period_start.
    always @(negedge clk) begin
        if (rst_n !== 1'b1) begin
            in_per = 0;
            pcount = 0;
        end else if (period_start === 1'b1) begin
            if (in_per) obs_q.push_back(cur);
            cur.idx   = pcount;
            pcount++;
            cur.len   = 1;
            cur.hi    = int'(pwm_out === 1'b1);
            cur.clamp = int'(duty_clamped === 1'b1);
            cur.armed = int'(armed === 1'b1);
            cur.rises = 0;
            prev_pwm  = (pwm_out === 1'b1);
            in_per    = 1;
        end else if (in_per) begin
            cur.len++;
            cur.hi    += int'(pwm_out === 1'b1);
            cur.clamp += int'(duty_clamped === 1'b1);
            cur.armed += int'(armed === 1'b1);
            if ((pwm_out === 1'b1) && !prev_pwm) cur.rises++;
            prev_pwm = (pwm_out === 1'b1);
        end
    end

    function automatic void model_idle();
        m_duty  = 8'h32;
        m_clamp = 0;
    endfunction

    function automatic void model_run(input logic [7:0] d);
        logic [7:0] t;
        t       = (d > 8'h64) ? 8'h64 : d;
        m_clamp = (d > 8'h64);
`ifdef SLEW_LIMIT_EN
        if (t > m_duty + 8'(MAXS))      m_duty = m_duty + 8'(MAXS);
        else if (m_duty > t + 8'(MAXS)) m_duty = m_duty - 8'(MAXS);
        else                            m_duty = t;
`else
        m_duty = t;
`endif
    endfunction

    function automatic void push_exp(input int armed_cycles);
        exp_t e;
        e.hi    = int'(m_duty) * CLK_DIV;
        e.clamp = m_clamp ? PERIOD : 0;
        e.armed = armed_cycles;
        exp_q.push_back(e);
    endfunction

    task automatic wait_pstart();
        int n;
        n = 0;
        do begin
            @(negedge clk); #1;
            n++;
        end while (period_start !== 1'b1 && n < 2 * PERIOD);
        checks++;
        if (period_start !== 1'b1) begin
            errors++;
            $display("FAIL period_start_timeout: no pulse after %0d cycles, required within %0d", n, PERIOD);
        end
    endtask

    // Latch d at the end of the current period, then move to the next (RUN) period.
    task automatic advance(input logic [7:0] d);
        duty_in = d;
        model_run(d);
        push_exp(PERIOD);
        wait_pstart();
    endtask

    task automatic advance_idle();
        model_idle();
        push_exp(0);
        wait_pstart();
    endtask

    // Called just after edge 1; ends at the start of the first period after the first RUN period.
    task automatic arm_sequence();
        @(negedge clk); #1;
        model_idle();
        push_exp(0);
        advance_idle();
        advance_idle();
        advance(duty_in);
        advance(duty_in);
    endtask

    task automatic test_reset();
        obs_t o;
        exp_t e;
        rst_n   = 1'b0;
        kill    = 1'b0;
        duty_in = 8'h50;
        repeat (3) @(negedge clk);
        #1;
        checks += 4;
        if (pwm_out !== 1'b0)      begin errors++; $display("FAIL reset_pwm_out got %b want 0", pwm_out); end
        if (armed !== 1'b0)        begin errors++; $display("FAIL reset_armed got %b want 0", armed); end
        if (period_start !== 1'b0) begin errors++; $display("FAIL reset_period_start got %b want 0", period_start); end
        if (duty_clamped !== 1'b0) begin errors++; $display("FAIL reset_duty_clamped got %b want 0", duty_clamped); end
        exp_q.delete();
        obs_q.delete();
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks += 2;
        if (period_start !== 1'b1) begin errors++; $display("FAIL edge1_period_start got %b want 1", period_start); end
        if (pwm_out !== 1'b1)      begin errors++; $display("FAIL edge1_pwm_out got %b want 1", pwm_out); end
        arm_sequence();
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            checks += 5;
            if (o.len !== PERIOD)  begin errors++; $display("FAIL reset_len p%0d got %0d want %0d", o.idx, o.len, PERIOD); end
            if (o.hi !== e.hi)     begin errors++; $display("FAIL reset_high p%0d got %0d want %0d", o.idx, o.hi, e.hi); end
            if (o.clamp !== e.clamp) begin errors++; $display("FAIL reset_clamp p%0d got %0d want %0d", o.idx, o.clamp, e.clamp); end
            if (o.armed !== e.armed) begin errors++; $display("FAIL reset_armed_cycles p%0d got %0d want %0d", o.idx, o.armed, e.armed); end
            if (o.rises !== 0)     begin errors++; $display("FAIL reset_glitch p%0d got %0d want 0", o.idx, o.rises); end
        end
    endtask

    task automatic test_run_extremes();
        obs_t o;
        exp_t e;
        advance(8'h00);
        advance(8'h64);
        advance(8'h50);
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            checks += 5;
            if (o.len !== PERIOD)  begin errors++; $display("FAIL extremes_len p%0d got %0d want %0d", o.idx, o.len, PERIOD); end
            if (o.hi !== e.hi)     begin errors++; $display("FAIL extremes_high p%0d got %0d want %0d", o.idx, o.hi, e.hi); end
            if (o.clamp !== e.clamp) begin errors++; $display("FAIL extremes_clamp p%0d got %0d want %0d", o.idx, o.clamp, e.clamp); end
            if (o.armed !== e.armed) begin errors++; $display("FAIL extremes_armed_cycles p%0d got %0d want %0d", o.idx, o.armed, e.armed); end
            if (o.rises !== 0)     begin errors++; $display("FAIL extremes_glitch p%0d got %0d want 0", o.idx, o.rises); end
        end
    endtask

    task automatic test_clamp();
        obs_t o;
        exp_t e;
        advance(8'h80);
        advance(8'h50);
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            checks += 5;
            if (o.len !== PERIOD)  begin errors++; $display("FAIL clamp_len p%0d got %0d want %0d", o.idx, o.len, PERIOD); end
            if (o.hi !== e.hi)     begin errors++; $display("FAIL clamp_high p%0d got %0d want %0d", o.idx, o.hi, e.hi); end
            if (o.clamp !== e.clamp) begin errors++; $display("FAIL clamp_flag_cycles p%0d got %0d want %0d", o.idx, o.clamp, e.clamp); end
            if (o.armed !== e.armed) begin errors++; $display("FAIL clamp_armed_cycles p%0d got %0d want %0d", o.idx, o.armed, e.armed); end
            if (o.rises !== 0)     begin errors++; $display("FAIL clamp_glitch p%0d got %0d want 0", o.idx, o.rises); end
        end
    endtask

    task automatic test_mid_change();
        obs_t o;
        exp_t e;
        advance(8'h20);
        repeat (150) @(negedge clk);
        #1;
        duty_in = 8'h40;
        model_run(8'h40);
        push_exp(PERIOD);
        wait_pstart();
        advance(8'h50);
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            checks += 5;
            if (o.len !== PERIOD)  begin errors++; $display("FAIL midchg_len p%0d got %0d want %0d", o.idx, o.len, PERIOD); end
            if (o.hi !== e.hi)     begin errors++; $display("FAIL midchg_high p%0d got %0d want %0d", o.idx, o.hi, e.hi); end
            if (o.clamp !== e.clamp) begin errors++; $display("FAIL midchg_clamp p%0d got %0d want %0d", o.idx, o.clamp, e.clamp); end
            if (o.armed !== e.armed) begin errors++; $display("FAIL midchg_armed_cycles p%0d got %0d want %0d", o.idx, o.armed, e.armed); end
            if (o.rises !== 0)     begin errors++; $display("FAIL midchg_glitch p%0d got %0d want 0", o.idx, o.rises); end
        end
    endtask

    task automatic test_mid_reset();
        obs_t o;
        exp_t e;
        advance(8'h80);
        repeat (50) @(negedge clk);
        #1;
        rst_n   = 1'b0;
        duty_in = 8'h50;
        @(posedge clk); #1;
        checks += 4;
        if (pwm_out !== 1'b0)      begin errors++; $display("FAIL midrst_pwm_out got %b want 0", pwm_out); end
        if (armed !== 1'b0)        begin errors++; $display("FAIL midrst_armed got %b want 0", armed); end
        if (period_start !== 1'b0) begin errors++; $display("FAIL midrst_period_start got %b want 0", period_start); end
        if (duty_clamped !== 1'b0) begin errors++; $display("FAIL midrst_duty_clamped got %b want 0", duty_clamped); end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            checks += 2;
            if (o.hi !== e.hi)     begin errors++; $display("FAIL prerst_high p%0d got %0d want %0d", o.idx, o.hi, e.hi); end
            if (o.armed !== e.armed) begin errors++; $display("FAIL prerst_armed_cycles p%0d got %0d want %0d", o.idx, o.armed, e.armed); end
        end
        exp_q.delete();
        obs_q.delete();
        repeat (2) @(negedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks += 2;
        if (period_start !== 1'b1) begin errors++; $display("FAIL midrst_edge1_period_start got %b want 1", period_start); end
        if (pwm_out !== 1'b1)      begin errors++; $display("FAIL midrst_edge1_pwm_out got %b want 1", pwm_out); end
        arm_sequence();
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            checks += 5;
            if (o.len !== PERIOD)  begin errors++; $display("FAIL rearm_len p%0d got %0d want %0d", o.idx, o.len, PERIOD); end
            if (o.hi !== e.hi)     begin errors++; $display("FAIL rearm_high p%0d got %0d want %0d", o.idx, o.hi, e.hi); end
            if (o.clamp !== e.clamp) begin errors++; $display("FAIL rearm_clamp p%0d got %0d want %0d", o.idx, o.clamp, e.clamp); end
            if (o.armed !== e.armed) begin errors++; $display("FAIL rearm_armed_cycles p%0d got %0d want %0d", o.idx, o.armed, e.armed); end
            if (o.rises !== 0)     begin errors++; $display("FAIL rearm_glitch p%0d got %0d want 0", o.idx, o.rises); end
        end
    endtask

`ifdef SLEW_LIMIT_EN
    task automatic test_slew();
        obs_t o;
        exp_t e;
        for (int i = 0; i < 60 && m_duty != 8'h32; i++) advance(8'h32);
        advance(8'h38);
        advance(8'h38);
        advance(8'h38);
        advance(8'h38);
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            checks += 3;
            if (o.hi !== e.hi)     begin errors++; $display("FAIL slew_high p%0d got %0d want %0d", o.idx, o.hi, e.hi); end
            if (o.armed !== e.armed) begin errors++; $display("FAIL slew_armed_cycles p%0d got %0d want %0d", o.idx, o.armed, e.armed); end
            if (o.rises !== 0)     begin errors++; $display("FAIL slew_glitch p%0d got %0d want 0", o.idx, o.rises); end
        end
    endtask
`endif

    task automatic test_kill();
        obs_t o;
        exp_t e;
        repeat (100) @(negedge clk);
        #1;
        kill = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (armed !== 1'b1) begin errors++; $display("FAIL kill_armed_hold got %b want 1", armed); end
        @(posedge clk); #1;
        checks++;
        if (armed !== 1'b0) begin errors++; $display("FAIL kill_armed_fall got %b want 0", armed); end
        @(negedge clk); #1;
        kill = 1'b0;
        e = exp_q.pop_back();
        e.armed = 102;
        exp_q.push_back(e);
        model_idle();
        push_exp(0);
        wait_pstart();
        advance_idle();
        advance_idle();
        advance(8'h50);
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            checks += 5;
            if (o.len !== PERIOD)  begin errors++; $display("FAIL kill_len p%0d got %0d want %0d", o.idx, o.len, PERIOD); end
            if (o.hi !== e.hi)     begin errors++; $display("FAIL kill_high p%0d got %0d want %0d", o.idx, o.hi, e.hi); end
            if (o.clamp !== e.clamp) begin errors++; $display("FAIL kill_clamp p%0d got %0d want %0d", o.idx, o.clamp, e.clamp); end
            if (o.armed !== e.armed) begin errors++; $display("FAIL kill_armed_cycles p%0d got %0d want %0d", o.idx, o.armed, e.armed); end
            if (o.rises !== 0)     begin errors++; $display("FAIL kill_glitch p%0d got %0d want 0", o.idx, o.rises); end
        end
    endtask

    task automatic test_kill_arm_complete();
        obs_t o;
        exp_t e;
        repeat (100) @(negedge clk);
        #1;
        kill = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        kill = 1'b0;
        e = exp_q.pop_back();
        e.armed = 102;
        exp_q.push_back(e);
        advance_idle();
        advance_idle();
        advance_idle();
        // last output cycle of the third arming period: the next edge is the completion boundary
        repeat (PERIOD - 2) @(negedge clk);
        #1;
        kill = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        kill = 1'b0;
        model_idle();
        push_exp(0);
        push_exp(0);
        wait_pstart();
        checks++;
        if (armed !== 1'b0) begin errors++; $display("FAIL killarm_armed got %b want 0", armed); end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            checks += 5;
            if (o.len !== PERIOD)  begin errors++; $display("FAIL killarm_len p%0d got %0d want %0d", o.idx, o.len, PERIOD); end
            if (o.hi !== e.hi)     begin errors++; $display("FAIL killarm_high p%0d got %0d want %0d", o.idx, o.hi, e.hi); end
            if (o.clamp !== e.clamp) begin errors++; $display("FAIL killarm_clamp p%0d got %0d want %0d", o.idx, o.clamp, e.clamp); end
            if (o.armed !== e.armed) begin errors++; $display("FAIL killarm_armed_cycles p%0d got %0d want %0d", o.idx, o.armed, e.armed); end
            if (o.rises !== 0)     begin errors++; $display("FAIL killarm_glitch p%0d got %0d want 0", o.idx, o.rises); end
        end
    endtask

    initial begin
        test_reset();
        test_run_extremes();
        test_clamp();
        test_mid_change();
        test_mid_reset();
`ifdef SLEW_LIMIT_EN
        test_slew();
`endif
        test_kill();
        test_kill_arm_complete();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/esc_pwm_driver.md
# esc_pwm_driver

Downstream stage of the motor offset summer: consumes the 8-bit duty command (0x00 = 0 % … 0x64 = 100 %) and drives one ESC with a glitch-free, period-synchronous PWM signal. It also runs a power-up arming sequence and a kill path, so the ESC sees only the idle duty (0x32) until the loop is allowed to command it. One instance is used per motor.

## Interface
Parameters:
- CLK_DIV, 500: clocks per 1 % duty step. PWM period is CLK_DIV*100 clocks (1 kHz at 50 MHz).
- ARM_PERIODS, 200: number of full PWM periods held at idle duty before commands are accepted.
- MAX_STEP, 2: maximum duty change per period. Used only with the slew limiter compiled in.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset. Synchronous, active-low.
- duty_in  in  8  commanded duty, 0x00–0x64. Larger values are clamped.
- kill  in  1  level input. Forces idle duty and disarms.
- pwm_out  out  1  ESC drive signal, registered.
- armed  out  1  high while in RUN.
- period_start  out  1  one-cycle pulse at the first clock of every PWM period.
- duty_clamped  out  1  high for the whole period whose active duty came from a duty_in value above 0x64.

## Operation
- Counters: a prescaler counts 0..CLK_DIV-1. A step counter counts 0..99 and advances when the prescaler wraps. Both wrap to 0 together at the period end.
- Output rule: pwm_out is the registered value of (step < duty_active).
  - duty_active = 0 gives a constant low output.
  - duty_active = 0x64 gives a constant high output.
- Period boundary: the last clock of a period is prescaler = CLK_DIV-1 and step = 99. duty_active changes only at this boundary.
- Duty latching: duty_in is sampled on the last clock of a period and applied to the next period. Mid-period changes to duty_in have no effect. Clamp rule: if duty_in > 0x64, the latched value is 0x64 and duty_clamped is set.
- FSM states:
  - ARMING: duty_active = 0x32. The period counter increments at each boundary. After ARM_PERIODS boundaries the FSM goes to RUN, and that same boundary latches duty_in.
  - RUN: the latching rule applies. armed = 1.
  - SAFE: duty_active = 0x32 and armed = 0.
- Transitions:
  - Any state, kill = 1: go to SAFE.
  - SAFE, kill = 0: go to ARMING at the next boundary, with the arm counter cleared.
- Kill timing: armed falls on the clock after kill is sampled high. duty_active becomes 0x32 at the next boundary, so the worst-case latency is one period.
- Simultaneous events: if kill is asserted on the boundary where arming would complete, SAFE wins.

## Timing
- Reset values: pwm_out = 0, armed = 0, period_start = 0, duty_clamped = 0. Internally: prescaler = 0, step = 0, state = ARMING, arm counter = 0, duty_active = 0x32.
- rst_n low at any clock, including mid-period, restores all reset values at that edge.
- Edge 1 is the first edge with rst_n high:
  - period_start = 1 and pwm_out = 1 in the cycle after edge 1.
  - pwm_out is high for exactly duty_active*CLK_DIV clocks per period.
  - period_start repeats every CLK_DIV*100 clocks.
- Latency: a duty_in value sampled at a boundary appears on pwm_out from the first cycle of the following period.
- armed rises in the same cycle as the period_start of the first RUN period.

## Configuration
- SLEW_LIMIT_EN defined:
  - In RUN, each boundary moves duty_active toward the clamped target by at most MAX_STEP, and lands exactly on the target when within MAX_STEP.
  - Entry to RUN starts slewing from 0x32.
  - Entry to SAFE or ARMING bypasses the limiter and jumps directly to 0x32.
- SLEW_LIMIT_EN undefined: duty_active takes the clamped target directly. MAX_STEP is unused.

## Structure
- Shared package drone_pwm_pkg:
  - DUTY_MAX = 8'h64.
  - DUTY_IDLE = 8'h32, the same idle value the summer adds.
  - STEPS_PER_PERIOD = 100.
  - esc_state_t enum: ARMING, RUN, SAFE.
- Sub-module pwm_period_timer: prescaler and step counter. Outputs step, period_start_int and period_end. Parameterised by CLK_DIV.
- The FSM, latch, clamp, slew logic and output registers stay in esc_pwm_driver.

## Test plan
All scenarios use CLK_DIV = 4 and ARM_PERIODS = 3.
- Reset release with duty_in = 0x50: three periods of 200 clocks high out of 400. armed rises at clock 1200 and the next period is 320 high.
- RUN with duty_in set to 0x00, then to 0x64: a constant low period, then a constant high period, with no glitch at the period boundaries.
- duty_in = 0x80 in RUN: the next period is 400 high and duty_clamped = 1 for exactly that period.
- duty_in changed mid-period from 0x20 to 0x40: the current period stays at 128 high and the next is 256 high.
- kill pulsed in RUN: armed falls on the next clock and the next period is 200 high. After release, three idle periods pass before armed rises again. kill on the arming-completion boundary leaves armed = 0.
- With SLEW_LIMIT_EN and MAX_STEP = 2: a duty_in step from 0x32 to 0x38 gives duty 0x34, 0x36, 0x38 over three periods. kill then jumps directly to 0x32.
